// File: rtl/wbs_bridge_pkg.sv
// Shared decode constants, FSM state type and slice geometry helpers for the
// Wishbone-to-debug-memory bridge.
package wbs_bridge_pkg;

  localparam logic [3:0]  REG_CH     = 4'd0;
  localparam logic [23:0] REG_MODE   = 24'd0;
  localparam logic [23:0] REG_DEBUG  = 24'd1;
  localparam logic [23:0] REG_STATUS = 24'd2;
  localparam logic [23:0] REG_ERRCLR = 24'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_WR_COMMIT,
    ST_ACK
  } state_t;

  function automatic int slice_count(input int dw);
    return (dw + 31) / 32;
  endfunction

  function automatic int slice_bits(input int dw);
    return (slice_count(dw) > 1) ? $clog2(slice_count(dw)) : 1;
  endfunction

endpackage

// File: rtl/wbs_slice_mux.sv
// Picks one 32-bit slice out of a memory word (zero-padded above MEM_DW) and
// merges byte-enabled bus data into the slice staging buffer.
module wbs_slice_mux
  import wbs_bridge_pkg::*;
#(
  parameter int MEM_DW = 64,
  localparam int NSL = slice_count(MEM_DW),
  localparam int SLW = slice_bits(MEM_DW),
  localparam int PW  = NSL * 32
) (
  input  logic [SLW-1:0]    slice,
  input  logic [3:0]        sel,
  input  logic [31:0]       dat,
  input  logic [MEM_DW-1:0] rword,
  input  logic [PW-1:0]     staging,
  output logic [31:0]       rd_slice,
  output logic [PW-1:0]     merged
);

  logic [PW-1:0] padded;

  always_comb begin
    padded   = PW'(rword);
    rd_slice = padded[32*slice +: 32];
    merged   = staging;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) merged[32*slice + 8*b +: 8] = dat[8*b +: 8];
    end
  end

endmodule

// File: rtl/wbs_mem_bridge.sv
// Wishbone slave exposing a small register bank (ch 0) and NUM_CH wide debug
// memories (ch 1..NUM_CH) as 32-bit slices.
//   state        | meaning
//   ST_IDLE      | waiting for cyc&stb; registers and errors answered directly
//   ST_RD_ISSUE  | one-cycle memory read strobe
//   ST_RD_WAIT   | wait RD_LAT cycles, then capture the requested slice
//   ST_WR_COMMIT | merge into staging; strobe the memory on the top slice
//   ST_ACK       | one-cycle acknowledge
module wbs_mem_bridge
  import wbs_bridge_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          MEM_DW    = 64,
  parameter int          MEM_DEPTH = 64,
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  localparam int         MEM_AW    = $clog2(MEM_DEPTH)
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_dat_i,
  input  logic [31:0]              wbs_adr_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  output logic                     wbs_mode,
  output logic                     wbs_debug,
  output logic [NUM_CH-1:0]        mem_csb0,
  output logic [NUM_CH-1:0]        mem_web0,
  output logic [MEM_AW-1:0]        mem_addr0,
  output logic [MEM_DW-1:0]        mem_wdata0,
  input  logic [NUM_CH*MEM_DW-1:0] mem_rdata0
);

  localparam int NSL = slice_count(MEM_DW);
  localparam int SLW = slice_bits(MEM_DW);
  localparam int PW  = NSL * 32;

  state_t            state;
  logic [3:0]        req_mem;
  logic [MEM_AW-1:0] req_word;
  logic [SLW-1:0]    req_slice;
  logic [3:0]        req_sel;
  logic [31:0]       req_dat;
  logic [PW-1:0]     staging;
  logic              staged;
  logic              err_sticky;
  logic [1:0]        lat_cnt;

  logic              req;
  logic [3:0]        adr_ch;
  logic [23:0]       reg_off;
  logic [SLW-1:0]    adr_slice;
  logic              is_reg;
  logic              bad;
  logic [31:0]       reg_rdata;
  logic [MEM_DW-1:0] rword;
  logic [31:0]       rd_slice;
  logic [PW-1:0]     merged;

  assign req       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign adr_ch    = wbs_adr_i[27:24];
  assign reg_off   = wbs_adr_i[23:0];
  assign adr_slice = wbs_adr_i[SLW-1:0];
  assign is_reg    = (adr_ch == REG_CH);
  assign rword     = mem_rdata0[req_mem*MEM_DW +: MEM_DW];

  // Word index is checked over all of adr[23:SLW] so addresses past the depth are caught.
  always_comb begin
    bad = (wbs_adr_i[31:28] != BASE_ADDR[31:28]) || (32'(adr_ch) > NUM_CH);
    if (is_reg) bad = bad || (reg_off > REG_ERRCLR);
    else        bad = bad || (32'(wbs_adr_i[23:SLW]) >= MEM_DEPTH)
                          || (32'(adr_slice) >= NSL) || !wbs_debug;
  end

  always_comb begin
    case (reg_off)
      REG_MODE:   reg_rdata = {31'b0, wbs_mode};
      REG_DEBUG:  reg_rdata = {31'b0, wbs_debug};
      REG_STATUS: reg_rdata = {29'b0, staged, err_sticky, state != ST_IDLE};
      default:    reg_rdata = 32'b0;
    endcase
  end

  wbs_slice_mux #(.MEM_DW(MEM_DW)) u_slice_mux (
    .slice    (req_slice),
    .sel      (req_sel),
    .dat      (req_dat),
    .rword    (rword),
    .staging  (staging),
    .rd_slice (rd_slice),
    .merged   (merged)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= ST_IDLE;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= 32'b0;
      wbs_mode   <= 1'b0;
      wbs_debug  <= 1'b0;
      mem_csb0   <= '1;
      mem_web0   <= '1;
      mem_addr0  <= '0;
      mem_wdata0 <= '0;
      staging    <= '0;
      staged     <= 1'b0;
      err_sticky <= 1'b0;
      req_mem    <= '0;
      req_word   <= '0;
      req_slice  <= '0;
      req_sel    <= '0;
      req_dat    <= '0;
      lat_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (req) begin
          req_mem   <= adr_ch - 4'd1;
          req_word  <= wbs_adr_i[SLW +: MEM_AW];
          req_slice <= adr_slice;
          req_sel   <= wbs_sel_i;
          req_dat   <= wbs_dat_i;
          if (bad) begin
            err_sticky <= 1'b1;
            wbs_dat_o  <= 32'b0;
            wbs_ack_o  <= 1'b1;
            state      <= ST_ACK;
          end else if (is_reg) begin
            if (!wbs_we_i) wbs_dat_o <= reg_rdata;
            else if (wbs_sel_i[0]) begin
              case (reg_off)
                REG_MODE:   wbs_mode  <= wbs_dat_i[0];
                REG_DEBUG:  wbs_debug <= wbs_dat_i[0];
                REG_ERRCLR: if (wbs_dat_i[0]) err_sticky <= 1'b0;
                default:    ;
              endcase
            end
            wbs_ack_o <= 1'b1;
            state     <= ST_ACK;
          end else if (wbs_we_i) begin
            state <= ST_WR_COMMIT;
          end else begin
            mem_csb0  <= ~(NUM_CH'(1) << (adr_ch - 4'd1));
            mem_addr0 <= wbs_adr_i[SLW +: MEM_AW];
            lat_cnt   <= 2'(RD_LAT - 1);
            state     <= ST_RD_ISSUE;
          end
        end
        ST_RD_ISSUE: begin
          mem_csb0 <= '1;
          state    <= wbs_cyc_i ? ST_RD_WAIT : ST_IDLE;
        end
        ST_RD_WAIT: begin
          if (!wbs_cyc_i) state <= ST_IDLE;
          else if (lat_cnt == 2'd0) begin
            wbs_dat_o <= rd_slice;
            wbs_ack_o <= 1'b1;
            state     <= ST_ACK;
          end else lat_cnt <= lat_cnt - 2'd1;
        end
        ST_WR_COMMIT: begin
          if (!wbs_cyc_i) state <= ST_IDLE;
          else begin
            staging <= merged;
            if (req_slice == SLW'(NSL - 1)) begin
              mem_csb0   <= ~(NUM_CH'(1) << req_mem);
              mem_web0   <= ~(NUM_CH'(1) << req_mem);
              mem_addr0  <= req_word;
              mem_wdata0 <= merged[MEM_DW-1:0];
              staged     <= 1'b0;
            end else staged <= 1'b1;
            wbs_ack_o <= 1'b1;
            state     <= ST_ACK;
          end
        end
        ST_ACK: begin
          wbs_ack_o <= 1'b0;
          mem_csb0  <= '1;
          mem_web0  <= '1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
